// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - shared state encoding and default parameters for lockstep mode control
package lockstep_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL    = 3'd0,
        ST_DRAIN_IN  = 3'd1,
        ST_LOCKSTEP  = 3'd2,
        ST_DRAIN_OUT = 3'd3,
        ST_ERROR     = 3'd4
    } ls_state_e;

    localparam int unsigned LS_NB_CORES      = 8;
    localparam int unsigned LS_OUTST_W       = 2;
    localparam int unsigned LS_DRAIN_TIMEOUT = 256;
    localparam int unsigned LS_ERR_CNT_W     = 16;

    // States in which the drain timer runs
    function automatic logic is_drain(input ls_state_e st);
        return (st == ST_DRAIN_IN) || (st == ST_DRAIN_OUT);
    endfunction

endpackage

// File: rtl/lockstep_outst_cnt.sv
// rtl/lockstep_outst_cnt.sv - per-core saturating outstanding-transaction counter
module lockstep_outst_cnt
    import lockstep_pkg::*;
#(
    parameter int unsigned OUTST_W = LS_OUTST_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    logic [OUTST_W-1:0] cnt;

    // Issue and return in the same cycle cancel; both ends saturate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (inc_i && !dec_i && cnt != CNT_MAX) begin
            cnt <= cnt + OUTST_W'(1);
        end else if (dec_i && !inc_i && cnt != '0) begin
            cnt <= cnt - OUTST_W'(1);
        end
    end

    assign zero_o = (cnt == '0);

endmodule

// File: rtl/lockstep_mode_ctrl.sv
// rtl/lockstep_mode_ctrl.sv - drains core TCDM traffic and switches between independent and lockstep mode
module lockstep_mode_ctrl
    import lockstep_pkg::*;
#(
    parameter int unsigned NB_CORES      = LS_NB_CORES,
    parameter int unsigned OUTST_W       = LS_OUTST_W,
    parameter int unsigned DRAIN_TIMEOUT = LS_DRAIN_TIMEOUT,
    parameter int unsigned ERR_CNT_W     = LS_ERR_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mode_req_i,
    input  logic                 err_clr_i,
    input  logic [NB_CORES-1:0]  core_req_i,
    input  logic [NB_CORES-1:0]  core_gnt_i,
    input  logic [NB_CORES-1:0]  core_rvalid_i,
    input  logic                 mismatch_i,
    output logic [NB_CORES-1:0]  core_halt_o,
    output logic                 lockstep_mode_o,
    output logic                 busy_o,
    output logic                 err_irq_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 timeout_o
);

    localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    ls_state_e            state, state_next;
    logic [NB_CORES-1:0]  cnt_zero;
    logic                 idle;
    logic [TMR_W-1:0]     drain_tmr;
    logic                 tmr_expired;
    logic                 to_event;
    logic                 mm_event;
    logic [NB_CORES-1:0]  halt_d;
    logic                 lock_d;
    logic                 busy_d;
    logic                 irq_d;

    for (genvar i = 0; i < NB_CORES; i++) begin : g_cnt
        lockstep_outst_cnt #(
            .OUTST_W (OUTST_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (core_req_i[i] & core_gnt_i[i]),
            .dec_i  (core_rvalid_i[i]),
            .zero_o (cnt_zero[i])
        );
    end

    assign idle        = (&cnt_zero) && (core_req_i == '0);
    assign tmr_expired = (drain_tmr == TMR_LAST);

    // State and registered outputs; outputs are loaded from the upcoming state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_NORMAL;
            core_halt_o     <= '0;
            lockstep_mode_o <= 1'b0;
            busy_o          <= 1'b0;
            err_irq_o       <= 1'b0;
        end else begin
            state           <= state_next;
            core_halt_o     <= halt_d;
            lockstep_mode_o <= lock_d;
            busy_o          <= busy_d;
            err_irq_o       <= irq_d;
        end
    end

    // Transition rules; cancel beats idle, idle beats timeout, mismatch beats exit request
    always_comb begin
        state_next = state;
        to_event   = 1'b0;
        mm_event   = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (mode_req_i) state_next = ST_DRAIN_IN;
            end
            ST_DRAIN_IN: begin
                if (!mode_req_i) begin
                    state_next = ST_NORMAL;
                end else if (idle) begin
                    state_next = ST_LOCKSTEP;
                end else if (tmr_expired) begin
                    state_next = ST_NORMAL;
                    to_event   = 1'b1;
                end
            end
            ST_LOCKSTEP: begin
                if (mismatch_i) begin
                    state_next = ST_ERROR;
                    mm_event   = 1'b1;
                end else if (!mode_req_i) begin
                    state_next = ST_DRAIN_OUT;
                end
            end
            ST_DRAIN_OUT: begin
                if (idle) begin
                    state_next = ST_NORMAL;
                end else if (tmr_expired) begin
                    state_next = ST_NORMAL;
                    to_event   = 1'b1;
                end
            end
            ST_ERROR: begin
                if (err_clr_i) state_next = ST_DRAIN_OUT;
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // Output values implied by the upcoming state
    always_comb begin
        halt_d = '0;
        lock_d = 1'b0;
        busy_d = 1'b0;
        irq_d  = 1'b0;
        case (state_next)
            ST_DRAIN_IN: begin
                halt_d = '1;
                busy_d = 1'b1;
            end
            ST_LOCKSTEP: begin
                lock_d = 1'b1;
            end
            ST_DRAIN_OUT: begin
                halt_d = '1;
                lock_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_ERROR: begin
                halt_d = '1;
                lock_d = 1'b1;
                busy_d = 1'b1;
                irq_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Drain timer restarts on every state change and advances while draining
    always_ff @(posedge clk_i) begin
        if (rst_i || state_next != state) begin
            drain_tmr <= '0;
        end else if (is_drain(state)) begin
            drain_tmr <= drain_tmr + TMR_W'(1);
        end
    end

    // Saturating mismatch counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (mm_event && err_cnt_o != '1) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

    // Sticky timeout flag; a fresh timeout wins over a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_o <= 1'b0;
        end else if (to_event) begin
            timeout_o <= 1'b1;
        end else if (err_clr_i) begin
            timeout_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// tb/tb_lockstep_mode_ctrl.sv - self-checking bench for lockstep_mode_ctrl
module tb_lockstep_mode_ctrl;

    localparam int NB_CORES      = 8;
    localparam int OUTST_W       = 2;
    localparam int DRAIN_TIMEOUT = 16;
    localparam int ERR_CNT_W     = 3;
    localparam int CNT_SAT       = (1 << OUTST_W) - 1;
    localparam int ERR_SAT       = (1 << ERR_CNT_W) - 1;
    localparam int HALT_ALL      = (1 << NB_CORES) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode_req = 1'b0;
    logic                 err_clr = 1'b0;
    logic [NB_CORES-1:0]  core_req = '0;
    logic [NB_CORES-1:0]  core_gnt = '0;
    logic [NB_CORES-1:0]  core_rvalid = '0;
    logic                 mismatch = 1'b0;
    logic [NB_CORES-1:0]  core_halt;
    logic                 lockstep_mode;
    logic                 busy;
    logic                 err_irq;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    lockstep_mode_ctrl #(
        .NB_CORES      (NB_CORES),
        .OUTST_W       (OUTST_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .ERR_CNT_W     (ERR_CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mode_req_i      (mode_req),
        .err_clr_i       (err_clr),
        .core_req_i      (core_req),
        .core_gnt_i      (core_gnt),
        .core_rvalid_i   (core_rvalid),
        .mismatch_i      (mismatch),
        .core_halt_o     (core_halt),
        .lockstep_mode_o (lockstep_mode),
        .busy_o          (busy),
        .err_irq_o       (err_irq),
        .err_cnt_o       (err_cnt),
        .timeout_o       (timeout)
    );

    // Reference model: phase of the mode switch, outstanding counts, drain age
    typedef enum int {M_IND, M_GOING_IN, M_LOCK, M_GOING_OUT, M_FAULT} mphase_t;
    mphase_t m_phase = M_IND;
    int      m_cnt [NB_CORES];
    int      m_age = 0;
    int      m_errs = 0;
    bit      m_to = 1'b0;

    always @(posedge clk) begin
        bit quiet;
        if (rst) begin
            m_phase = M_IND;
            for (int i = 0; i < NB_CORES; i++) m_cnt[i] = 0;
            m_age  = 0;
            m_errs = 0;
            m_to   = 1'b0;
        end else begin
            quiet = (core_req == '0);
            for (int i = 0; i < NB_CORES; i++) if (m_cnt[i] != 0) quiet = 1'b0;
            if (err_clr) m_to = 1'b0;
            case (m_phase)
                M_IND: if (mode_req) begin m_phase = M_GOING_IN; m_age = 1; end
                M_GOING_IN: begin
                    if (!mode_req) m_phase = M_IND;
                    else if (quiet) m_phase = M_LOCK;
                    else if (m_age == DRAIN_TIMEOUT) begin m_phase = M_IND; m_to = 1'b1; end
                    else m_age++;
                end
                M_LOCK: begin
                    if (mismatch) begin
                        m_phase = M_FAULT;
                        if (m_errs < ERR_SAT) m_errs++;
                    end else if (!mode_req) begin
                        m_phase = M_GOING_OUT; m_age = 1;
                    end
                end
                M_GOING_OUT: begin
                    if (quiet) m_phase = M_IND;
                    else if (m_age == DRAIN_TIMEOUT) begin m_phase = M_IND; m_to = 1'b1; end
                    else m_age++;
                end
                M_FAULT: if (err_clr) begin m_phase = M_GOING_OUT; m_age = 1; end
                default: m_phase = M_IND;
            endcase
            for (int i = 0; i < NB_CORES; i++) begin
                int v;
                v = m_cnt[i] + int'(core_req[i] & core_gnt[i]) - int'(core_rvalid[i]);
                m_cnt[i] = (v < 0) ? 0 : (v > CNT_SAT) ? CNT_SAT : v;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit draining, locked;
            draining = (m_phase == M_GOING_IN) || (m_phase == M_GOING_OUT) || (m_phase == M_FAULT);
            locked   = (m_phase == M_LOCK) || (m_phase == M_GOING_OUT) || (m_phase == M_FAULT);
            check("halt",    32'(core_halt),     draining ? HALT_ALL : 0);
            check("lock",    32'(lockstep_mode), 32'(locked));
            check("busy",    32'(busy),          32'(draining));
            check("irq",     32'(err_irq),       32'(m_phase == M_FAULT));
            check("err_cnt", 32'(err_cnt),       m_errs);
            check("timeout", 32'(timeout),       32'(m_to));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_halt", 32'(core_halt), 0);
        check("rst_lock", 32'(lockstep_mode), 0);
        check("rst_cnt",  32'(err_cnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Entry with core 3 holding one outstanding transaction
        core_req[3] = 1'b1; core_gnt[3] = 1'b1;
        tick();
        core_req = '0; core_gnt = '0;
        mode_req = 1'b1;
        tick();                                  // cycle 0 edge
        for (int c = 1; c < 5; c++) tick();
        core_rvalid[3] = 1'b1;
        tick();                                  // cycle 5 edge
        core_rvalid = '0;
        check("entry_c6_lock", 32'(lockstep_mode), 0);
        check("entry_c6_halt", 32'(core_halt), HALT_ALL);
        tick();
        check("entry_c7_lock", 32'(lockstep_mode), 1);
        check("entry_c7_halt", 32'(core_halt), 0);

        // Exit while idle
        mode_req = 1'b0;
        tick();
        check("exit_drain_busy", 32'(busy), 1);
        check("exit_drain_lock", 32'(lockstep_mode), 1);
        tick();
        check("exit_done_lock", 32'(lockstep_mode), 0);
        check("exit_done_busy", 32'(busy), 0);

        // Mismatch, acknowledge, drain out
        mode_req = 1'b1;
        tick();
        tick();
        mismatch = 1'b1;
        tick();
        mismatch = 1'b0;
        check("mm_irq", 32'(err_irq), 1);
        check("mm_cnt", 32'(err_cnt), 1);
        tick();
        err_clr = 1'b1; mode_req = 1'b0;
        tick();
        err_clr = 1'b0;
        check("mm_clr_irq",  32'(err_irq), 0);
        check("mm_clr_busy", 32'(busy), 1);
        tick();
        check("mm_normal_lock", 32'(lockstep_mode), 0);

        // Drain timeout with core 0 never returning
        core_req[0] = 1'b1; core_gnt[0] = 1'b1;
        tick();
        core_req = '0; core_gnt = '0;
        mode_req = 1'b1;
        tick();
        for (int c = 1; c < DRAIN_TIMEOUT; c++) tick();
        check("to_still_busy", 32'(busy), 1);
        check("to_not_yet",    32'(timeout), 0);
        tick();
        mode_req = 1'b0;
        check("to_busy", 32'(busy), 0);
        check("to_flag", 32'(timeout), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_cleared", 32'(timeout), 0);
        core_rvalid[0] = 1'b1;
        tick();
        core_rvalid = '0;

        // Cancel in the same cycle idle is reached
        core_req[1] = 1'b1; core_gnt[1] = 1'b1;
        tick();
        core_req = '0; core_gnt = '0;
        mode_req = 1'b1;
        tick();
        core_rvalid[1] = 1'b1;
        tick();
        core_rvalid = '0;
        mode_req = 1'b0;
        tick();
        check("cancel_lock", 32'(lockstep_mode), 0);
        check("cancel_halt", 32'(core_halt), 0);

        // Simultaneous issue and return on core 2, then reset mid-drain
        core_req[2] = 1'b1; core_gnt[2] = 1'b1;
        tick();
        core_rvalid[2] = 1'b1;
        tick();
        core_req = '0; core_gnt = '0; core_rvalid = '0;
        mode_req = 1'b1;
        tick();
        tick();
        tick();
        check("c2_held_halt", 32'(core_halt), HALT_ALL);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_halt", 32'(core_halt), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_lock", 32'(lockstep_mode), 0);
        tick();
        tick();
        check("post_rst_lock", 32'(lockstep_mode), 1);
        mode_req = 1'b0;
        tick();
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit quiet_cyc;
            quiet_cyc   = ($urandom_range(0, 1) == 0);
            core_req    = quiet_cyc ? '0 : NB_CORES'($urandom & $urandom & $urandom);
            core_gnt    = NB_CORES'($urandom);
            core_rvalid = NB_CORES'($urandom);
            if ($urandom_range(0, 15) == 0) mode_req = ~mode_req;
            mismatch = ($urandom_range(0, 7) == 0);
            err_clr  = ($urandom_range(0, 11) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; mismatch = 1'b0; err_clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
